dis_gpu_interface: RTL and testbench

Dispatcher-side bridge between the dispatch controller and the compute units (CUs). Alloc path: latches each workgroup (WG) the controller approves and drives it to the target CU over a valid/ready handshake, holding `gpu_interface_alloc_available` low while a dispatch is outstanding. Dealloc path: queues WG-completion reports from the CUs in a FIFO and presents the head to the controller until it is consumed. Sits directly downstream (alloc) and upstream (dealloc) of the dispatch controller.

---
 rtl/dis_gpu_interface_pkg.sv | 18 +
 rtl/dis_dealloc_fifo.sv | 68 ++++++
 rtl/dis_gpu_interface.sv | 126 ++++++++++++
 tb/tb_dis_gpu_interface.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dis_gpu_interface_pkg.sv
// Shared dispatcher package.
// Holds the default widths used by the dispatcher blocks and the one-hot
// state encoding of the alloc FSM. The one-hot encoding matches the other
// dispatcher FSMs.
package dis_gpu_interface_pkg;

  localparam int DIS_NUMBER_CU               = 64;
  localparam int DIS_CU_ID_WIDTH             = 6;
  localparam int DIS_WG_ID_WIDTH             = 15;
  localparam int DIS_WF_COUNT_WIDTH          = 4;
  localparam int DIS_DEALLOC_FIFO_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b01,
    ST_DISPATCH = 2'b10
  } alloc_state_t;

endpackage

// File: rtl/dis_dealloc_fifo.sv
// Synchronous FIFO for workgroup-completion reports.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   push_valid   : producer offers push_data
//   push_data    : entry to enqueue
//   push_ready   : FIFO not full (no same-cycle bypass from a pop)
//   pop_en       : consume the head (ignored while empty)
//   head_valid   : FIFO not empty
//   head_data    : current head, read from registered storage
// Pointers carry one extra bit so full and empty are distinguishable.
module dis_dealloc_fifo #(
  parameter int ADDR_W  = 2,
  parameter int ENTRY_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               push_ready,
  input  logic               pop_en,
  output logic               head_valid,
  output logic [ENTRY_W-1:0] head_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Readiness depends only on the current fill level, so a pop in the same
  // cycle cannot open a slot for a push while full.
  assign push_ready = !full;
  assign push       = push_valid && !full;
  assign pop        = pop_en && !empty;

  assign head_valid = !empty;
  assign head_data  = mem[rd_ptr[ADDR_W-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        wr_ptr                  <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/dis_gpu_interface.sv
// Dispatcher-side bridge between the dispatch controller and the CUs.
// Alloc path: latches an approved WG and presents it to the target CU over
// a valid/ready handshake; alloc_available is low while it is outstanding.
// Dealloc path: queues CU completion reports and presents the head to the
// controller until it pulses dealloc_valid.
// Ports:
//   clk, rst                          : clock, synchronous active-low reset
//   dis_controller_wg_alloc_valid     : pulse, dispatch the pending WG
//   alloc_wg_id/alloc_cu_id/alloc_wf_count : pending WG attributes
//   dis_controller_wg_dealloc_valid   : pulse, FIFO head consumed
//   gpu_interface_alloc_available     : dispatch channel idle
//   gpu_interface_dealloc_available   : completion FIFO non-empty
//   gpu_interface_cu_id/_dealloc_wg_id: completion FIFO head
//   dispatch_valid/_cu_id/_wg_id/_wf_count, dispatch_ready : CU dispatch
//   cu_wg_done_valid/_cu_id/_wg_id, cu_wg_done_ready        : CU reports
module dis_gpu_interface
  import dis_gpu_interface_pkg::*;
#(
  parameter int CU_ID_WIDTH             = DIS_CU_ID_WIDTH,
  parameter int WG_ID_WIDTH             = DIS_WG_ID_WIDTH,
  parameter int WF_COUNT_WIDTH          = DIS_WF_COUNT_WIDTH,
  parameter int DEALLOC_FIFO_ADDR_WIDTH = DIS_DEALLOC_FIFO_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dis_controller_wg_alloc_valid,
  input  logic [WG_ID_WIDTH-1:0]    alloc_wg_id,
  input  logic [CU_ID_WIDTH-1:0]    alloc_cu_id,
  input  logic [WF_COUNT_WIDTH-1:0] alloc_wf_count,
  input  logic                      dis_controller_wg_dealloc_valid,
  output logic                      gpu_interface_alloc_available,
  output logic                      gpu_interface_dealloc_available,
  output logic [CU_ID_WIDTH-1:0]    gpu_interface_cu_id,
  output logic [WG_ID_WIDTH-1:0]    gpu_interface_dealloc_wg_id,
  output logic                      dispatch_valid,
  output logic [CU_ID_WIDTH-1:0]    dispatch_cu_id,
  output logic [WG_ID_WIDTH-1:0]    dispatch_wg_id,
  output logic [WF_COUNT_WIDTH-1:0] dispatch_wf_count,
  input  logic                      dispatch_ready,
  input  logic                      cu_wg_done_valid,
  input  logic [CU_ID_WIDTH-1:0]    cu_wg_done_cu_id,
  input  logic [WG_ID_WIDTH-1:0]    cu_wg_done_wg_id,
  output logic                      cu_wg_done_ready
);

  localparam int ENTRY_W = CU_ID_WIDTH + WG_ID_WIDTH;

  alloc_state_t              state;
  alloc_state_t              state_nxt;
  logic                      load_wg;
  logic [WG_ID_WIDTH-1:0]    wg_id_p1;
  logic [CU_ID_WIDTH-1:0]    cu_id_p1;
  logic [WF_COUNT_WIDTH-1:0] wf_count_p1;
  logic [ENTRY_W-1:0]        head_data;

  // Alloc FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Alloc FSM: next state and outputs. A pulse seen while dispatching is
  // dropped so the fields the CU is looking at never change under it.
  always_comb begin
    state_nxt                     = state;
    load_wg                       = 1'b0;
    gpu_interface_alloc_available = 1'b0;
    dispatch_valid                = 1'b0;
    case (state)
      ST_IDLE: begin
        gpu_interface_alloc_available = 1'b1;
        if (dis_controller_wg_alloc_valid) begin
          load_wg   = 1'b1;
          state_nxt = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        dispatch_valid = 1'b1;
        if (dispatch_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latched WG attributes (stage p1, one edge after the alloc pulse)
  always_ff @(posedge clk) begin
    if (!rst) begin
      wg_id_p1    <= '0;
      cu_id_p1    <= '0;
      wf_count_p1 <= '0;
    end else if (load_wg) begin
      wg_id_p1    <= alloc_wg_id;
      cu_id_p1    <= alloc_cu_id;
      wf_count_p1 <= alloc_wf_count;
    end
  end

  assign dispatch_wg_id    = wg_id_p1;
  assign dispatch_cu_id    = cu_id_p1;
  assign dispatch_wf_count = wf_count_p1;

  dis_dealloc_fifo #(
    .ADDR_W  (DEALLOC_FIFO_ADDR_WIDTH),
    .ENTRY_W (ENTRY_W)
  ) u_dealloc_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (cu_wg_done_valid),
    .push_data  ({cu_wg_done_cu_id, cu_wg_done_wg_id}),
    .push_ready (cu_wg_done_ready),
    .pop_en     (dis_controller_wg_dealloc_valid),
    .head_valid (gpu_interface_dealloc_available),
    .head_data  (head_data)
  );

  assign gpu_interface_cu_id         = head_data[ENTRY_W-1:WG_ID_WIDTH];
  assign gpu_interface_dealloc_wg_id = head_data[WG_ID_WIDTH-1:0];

endmodule

// File: tb/tb_dis_gpu_interface.sv
module tb_dis_gpu_interface;
  import dis_gpu_interface_pkg::*;

  localparam int CW = DIS_CU_ID_WIDTH;
  localparam int WW = DIS_WG_ID_WIDTH;
  localparam int FW = DIS_WF_COUNT_WIDTH;
  localparam int FIFO_DEPTH = 1 << DIS_DEALLOC_FIFO_ADDR_WIDTH;

  logic          clk;
  logic          rst;
  logic          dis_controller_wg_alloc_valid;
  logic [WW-1:0] alloc_wg_id;
  logic [CW-1:0] alloc_cu_id;
  logic [FW-1:0] alloc_wf_count;
  logic          dis_controller_wg_dealloc_valid;
  logic          gpu_interface_alloc_available;
  logic          gpu_interface_dealloc_available;
  logic [CW-1:0] gpu_interface_cu_id;
  logic [WW-1:0] gpu_interface_dealloc_wg_id;
  logic          dispatch_valid;
  logic [CW-1:0] dispatch_cu_id;
  logic [WW-1:0] dispatch_wg_id;
  logic [FW-1:0] dispatch_wf_count;
  logic          dispatch_ready;
  logic          cu_wg_done_valid;
  logic [CW-1:0] cu_wg_done_cu_id;
  logic [WW-1:0] cu_wg_done_wg_id;
  logic          cu_wg_done_ready;

  dis_gpu_interface dut (
    .clk                             (clk),
    .rst                             (rst),
    .dis_controller_wg_alloc_valid   (dis_controller_wg_alloc_valid),
    .alloc_wg_id                     (alloc_wg_id),
    .alloc_cu_id                     (alloc_cu_id),
    .alloc_wf_count                  (alloc_wf_count),
    .dis_controller_wg_dealloc_valid (dis_controller_wg_dealloc_valid),
    .gpu_interface_alloc_available   (gpu_interface_alloc_available),
    .gpu_interface_dealloc_available (gpu_interface_dealloc_available),
    .gpu_interface_cu_id             (gpu_interface_cu_id),
    .gpu_interface_dealloc_wg_id     (gpu_interface_dealloc_wg_id),
    .dispatch_valid                  (dispatch_valid),
    .dispatch_cu_id                  (dispatch_cu_id),
    .dispatch_wg_id                  (dispatch_wg_id),
    .dispatch_wf_count               (dispatch_wf_count),
    .dispatch_ready                  (dispatch_ready),
    .cu_wg_done_valid                (cu_wg_done_valid),
    .cu_wg_done_cu_id                (cu_wg_done_cu_id),
    .cu_wg_done_wg_id                (cu_wg_done_wg_id),
    .cu_wg_done_ready                (cu_wg_done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a busy flag with the accepted WG, and a queue of
  // pending completion reports {cu, wg}.
  bit             m_busy;
  logic [WW-1:0]  m_wg;
  logic [CW-1:0]  m_cu;
  logic [FW-1:0]  m_wf;
  logic [CW+WW-1:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit full, empty;
    if (!rst) begin
      m_busy = 1'b0;
      m_wg = '0; m_cu = '0; m_wf = '0;
      m_q.delete();
    end else begin
      if (m_busy) begin
        if (dispatch_ready) m_busy = 1'b0;
      end else if (dis_controller_wg_alloc_valid) begin
        m_busy = 1'b1;
        m_wg = alloc_wg_id; m_cu = alloc_cu_id; m_wf = alloc_wf_count;
      end
      full  = (m_q.size() == FIFO_DEPTH);
      empty = (m_q.size() == 0);
      if (dis_controller_wg_dealloc_valid && !empty) void'(m_q.pop_front());
      if (cu_wg_done_valid && !full) m_q.push_back({cu_wg_done_cu_id, cu_wg_done_wg_id});
    end
  endtask

  task automatic compare_all();
    logic [CW+WW-1:0] h;
    chk("alloc_avail", 32'(gpu_interface_alloc_available), 32'(!m_busy));
    chk("dispatch_valid", 32'(dispatch_valid), 32'(m_busy));
    chk("dispatch_wg", 32'(dispatch_wg_id), 32'(m_wg));
    chk("dispatch_cu", 32'(dispatch_cu_id), 32'(m_cu));
    chk("dispatch_wf", 32'(dispatch_wf_count), 32'(m_wf));
    chk("dealloc_avail", 32'(gpu_interface_dealloc_available), 32'(m_q.size() != 0));
    chk("done_ready", 32'(cu_wg_done_ready), 32'(m_q.size() < FIFO_DEPTH));
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("head_cu", 32'(gpu_interface_cu_id), 32'(h[CW+WW-1:WW]));
      chk("head_wg", 32'(gpu_interface_dealloc_wg_id), 32'(h[WW-1:0]));
    end
  endtask

  // Inputs present at the edge are applied to the model, then outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic report(input logic [CW-1:0] cu, input logic [WW-1:0] wg);
    cu_wg_done_valid = 1'b1; cu_wg_done_cu_id = cu; cu_wg_done_wg_id = wg;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b0;
    dis_controller_wg_alloc_valid = 1'b0;
    alloc_wg_id = '0; alloc_cu_id = '0; alloc_wf_count = '0;
    dis_controller_wg_dealloc_valid = 1'b0;
    dispatch_ready = 1'b0;
    cu_wg_done_valid = 1'b0; cu_wg_done_cu_id = '0; cu_wg_done_wg_id = '0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_alloc_avail", 32'(gpu_interface_alloc_available), 32'd1);
    chk("rst_dealloc_avail", 32'(gpu_interface_dealloc_available), 32'd0);
    chk("rst_dispatch_valid", 32'(dispatch_valid), 32'd0);
    chk("rst_done_ready", 32'(cu_wg_done_ready), 32'd1);
    chk("rst_head_cu", 32'(gpu_interface_cu_id), 32'd0);
    chk("rst_head_wg", 32'(gpu_interface_dealloc_wg_id), 32'd0);
    chk("rst_fields", 32'({dispatch_cu_id, dispatch_wg_id, dispatch_wf_count}), 32'd0);
    rst = 1'b1;
    tick();

    // Dispatch held by a stalled CU, with an overlapping alloc pulse
    dis_controller_wg_alloc_valid = 1'b1;
    alloc_wg_id = 15'h12; alloc_cu_id = 6'd5; alloc_wf_count = 4'd3;
    tick();
    dis_controller_wg_alloc_valid = 1'b0;
    chk("disp_valid_n1", 32'(dispatch_valid), 32'd1);
    chk("disp_avail_n1", 32'(gpu_interface_alloc_available), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        dis_controller_wg_alloc_valid = 1'b1;
        alloc_wg_id = 15'h34; alloc_cu_id = 6'd7; alloc_wf_count = 4'd9;
      end
      tick();
      dis_controller_wg_alloc_valid = 1'b0;
      chk("stall_wg", 32'(dispatch_wg_id), 32'h12);
      chk("stall_cu", 32'(dispatch_cu_id), 32'd5);
      chk("stall_wf", 32'(dispatch_wf_count), 32'd3);
      chk("stall_valid", 32'(dispatch_valid), 32'd1);
    end
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    chk("release_valid", 32'(dispatch_valid), 32'd0);
    chk("release_avail", 32'(gpu_interface_alloc_available), 32'd1);

    // Fill the FIFO with 5 back-to-back reports
    for (int i = 1; i <= 5; i++) begin
      report(CW'(i), WW'(16'h100 + i));
      tick();
      if (i == 4) chk("fill_ready_low", 32'(cu_wg_done_ready), 32'd0);
    end
    cu_wg_done_valid = 1'b0;
    chk("fill_head_cu", 32'(gpu_interface_cu_id), 32'd1);
    tick();
    chk("fill_head_stable", 32'(gpu_interface_cu_id), 32'd1);

    // Drain in order, then pop while empty
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", 32'(gpu_interface_cu_id), 32'(i));
      dis_controller_wg_dealloc_valid = 1'b1;
      tick();
    end
    dis_controller_wg_dealloc_valid = 1'b0;
    chk("drain_empty", 32'(gpu_interface_dealloc_available), 32'd0);
    dis_controller_wg_dealloc_valid = 1'b1;
    tick();
    dis_controller_wg_dealloc_valid = 1'b0;
    chk("empty_pop_avail", 32'(gpu_interface_dealloc_available), 32'd0);
    chk("empty_pop_ready", 32'(cu_wg_done_ready), 32'd1);

    // Concurrent push/pop with two entries
    report(6'd1, 15'h201); tick();
    report(6'd2, 15'h202); tick();
    report(6'd9, 15'h209); dis_controller_wg_dealloc_valid = 1'b1;
    tick();
    cu_wg_done_valid = 1'b0; dis_controller_wg_dealloc_valid = 1'b0;
    chk("pp_head", 32'(gpu_interface_cu_id), 32'd2);
    chk("pp_ready", 32'(cu_wg_done_ready), 32'd1);
    // Fill to 4, then push plus pop while full: push rejected
    report(6'd10, 15'h20a); tick();
    report(6'd11, 15'h20b); tick();
    chk("pp_full", 32'(cu_wg_done_ready), 32'd0);
    report(6'd12, 15'h20c); dis_controller_wg_dealloc_valid = 1'b1;
    tick();
    cu_wg_done_valid = 1'b0;
    chk("full_pp_ready", 32'(cu_wg_done_ready), 32'd1);
    chk("full_pp_head", 32'(gpu_interface_cu_id), 32'd9);
    tick(); tick();
    chk("three_left_avail", 32'(gpu_interface_dealloc_available), 32'd1);
    chk("three_left_head", 32'(gpu_interface_cu_id), 32'd11);
    tick();
    dis_controller_wg_dealloc_valid = 1'b0;
    chk("three_drained", 32'(gpu_interface_dealloc_available), 32'd0);

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      rst = (r[7:0] != 8'd0);
      dis_controller_wg_alloc_valid = (r[9:8] == 2'd0);
      dispatch_ready = r[10];
      cu_wg_done_valid = r[12] | r[11];
      dis_controller_wg_dealloc_valid = r[13] & r[14];
      r = $urandom();
      alloc_wg_id = r[WW-1:0];
      alloc_cu_id = CW'($urandom_range(DIS_NUMBER_CU - 1));
      alloc_wf_count = r[WW+FW-1:WW];
      r = $urandom();
      cu_wg_done_wg_id = r[WW-1:0];
      cu_wg_done_cu_id = CW'($urandom_range(DIS_NUMBER_CU - 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
